// File: rtl/demux_route_ctrl.sv
// Buffers (data, dest) words in a small FIFO and sequences a 1-to-4 demux so each
// word reaches exactly one sink. Optional head-of-line stall timeout: ROUTE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | FIFO empty, no sink valid, Selector holds its last value
// PRESENT | head word presented to sink Selector, held until that sink accepts
// DROP    | head word stalled too long, discarded this cycle (ROUTE_TIMEOUT_EN only)
module demux_route_ctrl #(
  parameter int DATA_LENGTH    = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          In_Valid,
  output logic                          In_Ready,
  input  logic [DATA_LENGTH-1:0]        In_Data,
  input  logic [1:0]                    In_Dest,
  output logic [1:0]                    Selector,
  output logic [DATA_LENGTH-1:0]        Demux_Data,
  output logic [3:0]                    Out_Valid,
  input  logic [3:0]                    Out_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
  output logic                          Drop_Pulse
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef ROUTE_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, PRESENT, DROP} state_t;
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`else
  typedef enum logic [1:0] {IDLE, PRESENT} state_t;
`endif

  logic [DATA_LENGTH-1:0] mem_data [FIFO_DEPTH];
  logic [1:0]             mem_dest [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count, count_d;
  logic [1:0]             sel_q, head_dest;
  logic [DATA_LENGTH-1:0] head_data;
  logic                   push, pop, discard, advance;
  state_t                 state_q, state_d;

  assign head_dest = mem_dest[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  always_comb begin
    push    = In_Valid & In_Ready;
    pop     = (state_q == PRESENT) & Out_Ready[head_dest];
    discard = 1'b0;
`ifdef ROUTE_TIMEOUT_EN
    discard = (state_q == DROP);
`endif
    advance = pop | discard;
    count_d = count;
    if (push && !advance)
      count_d = count + 1'b1;
    else if (!push && advance)
      count_d = count - 1'b1;
    state_d = (count_d != '0) ? PRESENT : IDLE;
`ifdef ROUTE_TIMEOUT_EN
    // Counter restarts on every pop and on every fresh entry to PRESENT.
    stall_d = '0;
    if (state_q == PRESENT && !pop) begin
      if (stall_q == STALL_LAST)
        state_d = DROP;
      else
        stall_d = stall_q + 1'b1;
    end
`endif
  end

  always_comb begin
    In_Ready   = ~reset & (count != FULL_CNT);
    Out_Valid  = 4'b0000;
    Selector   = sel_q;
    Demux_Data = '0;
    Fifo_Count = count;
    Drop_Pulse = 1'b0;
    if (state_q == PRESENT) begin
      Selector   = head_dest;
      Demux_Data = head_data;
      if (!reset)
        Out_Valid = 4'b0001 << head_dest;
    end
`ifdef ROUTE_TIMEOUT_EN
    Drop_Pulse = (state_q == DROP);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state_q <= IDLE;
      sel_q   <= 2'd0;
`ifdef ROUTE_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= In_Data;
        mem_dest[wr_ptr] <= In_Dest;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (advance)
        rd_ptr <= rd_ptr + 1'b1;
      if (state_q == PRESENT)
        sel_q <= head_dest;
      count   <= count_d;
      state_q <= state_d;
`ifdef ROUTE_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed plus randomized bench for demux_route_ctrl, checked against a queue-based
// reference model of the routing rules (timeout rules follow ROUTE_TIMEOUT_EN).
module tb_demux_route_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    dest;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          In_Valid;
  logic          In_Ready;
  logic [DW-1:0] In_Data;
  logic [1:0]    In_Dest;
  logic [1:0]    Selector;
  logic [DW-1:0] Demux_Data;
  logic [3:0]    Out_Valid;
  logic [3:0]    Out_Ready;
  logic [2:0]    Fifo_Count;
  logic          Drop_Pulse;

  int n_cmp = 0;
  int n_err = 0;

  ent_t       q[$];
  logic [1:0] last_sel = 2'd0;
  int         stall = 0;
  bit         drop_now = 0;

  demux_route_ctrl #(.DATA_LENGTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Data(In_Data), .In_Dest(In_Dest), .Selector(Selector),
    .Demux_Data(Demux_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Fifo_Count(Fifo_Count), .Drop_Pulse(Drop_Pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance model at the edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [1:0] ds,
                      input logic [3:0] ordy, input logic rst);
    logic [3:0]    e_ov;
    logic [1:0]    e_sel;
    logic [DW-1:0] e_dd;
    logic          e_dp;
    bit            do_push;
    reset = rst; In_Valid = iv; In_Data = d; In_Dest = ds; Out_Ready = ordy;
    #1;
    e_ov = 4'b0000; e_sel = last_sel; e_dd = '0; e_dp = 1'b0;
    if (drop_now) e_dp = 1'b1;
    else if (q.size() > 0) begin
      e_ov  = 4'b0001 << q[0].dest;
      e_sel = q[0].dest;
      e_dd  = q[0].data;
    end
    if (rst) begin
      chk("in_ready_rst", 64'(In_Ready), 64'(1'b0));
      chk("out_valid_rst", 64'(Out_Valid), 64'(4'b0000));
    end else begin
      chk("in_ready", 64'(In_Ready), 64'(q.size() < DEPTH));
      chk("fifo_count", 64'(Fifo_Count), 64'(q.size()));
      chk("out_valid", 64'(Out_Valid), 64'(e_ov));
      chk("selector", 64'(Selector), 64'(e_sel));
      chk("demux_data", 64'(Demux_Data), 64'(e_dd));
      chk("drop_pulse", 64'(Drop_Pulse), 64'(e_dp));
    end
    do_push = iv && !rst && (q.size() < DEPTH);
    @(posedge clk);
    if (rst) begin
      q.delete(); last_sel = 2'd0; stall = 0; drop_now = 0;
    end else begin
      if (drop_now) begin
        void'(q.pop_front()); drop_now = 0; stall = 0;
      end else if (q.size() > 0) begin
        last_sel = q[0].dest;
        if (ordy[q[0].dest]) begin
          void'(q.pop_front()); stall = 0;
        end else begin
          stall++;
`ifdef ROUTE_TIMEOUT_EN
          if (stall == TMO) begin drop_now = 1; stall = 0; end
`endif
        end
      end
      if (do_push) q.push_back('{data: d, dest: ds});
    end
    @(negedge clk);
  endtask

  initial begin
    // 1: reset, then idle
    step(0, '0, 2'd0, 4'b0000, 1);
    step(0, '0, 2'd0, 4'b0000, 1);
    step(0, '0, 2'd0, 4'b0000, 0);
    // 2: single pass-through word
    step(1, 32'hA5A5_0001, 2'd2, 4'b1111, 0);
    step(0, '0, 2'd0, 4'b1111, 0);
    step(0, '0, 2'd0, 4'b1111, 0);
    // 3: fill with sinks stalled, fifth refused, then drain in order
    for (int i = 0; i < 5; i++) step(1, 32'h3000_0000 + i, 2'(i), 4'b0000, 0);
    step(1, 32'h3000_00FF, 2'd1, 4'b0000, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 2'd0, 4'b1111, 0);
    // 4: push+pop at count 2, then wrap pointers several times
    step(1, 32'h4000_0001, 2'd1, 4'b0000, 0);
    step(1, 32'h4000_0002, 2'd3, 4'b0000, 0);
    step(1, 32'h4000_0003, 2'd0, 4'b1111, 0);
    for (int i = 0; i < 10; i++) step(1, 32'h4100_0000 + i, 2'(i * 3), 4'b1111, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 2'd0, 4'b1111, 0);
    // 5: head for sink 3 stalled with only sink 0 ready
    step(1, 32'h5000_0003, 2'd3, 4'b0001, 0);
    step(1, 32'h5000_0004, 2'd0, 4'b0001, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 2'd0, 4'b0001, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 2'd0, 4'b1111, 0);
    // 6: reset mid-stall with three words buffered, nothing delivered afterwards
    for (int i = 0; i < 3; i++) step(1, 32'h6000_0000 + i, 2'd2, 4'b0000, 0);
    step(0, '0, 2'd0, 4'b0000, 0);
    step(1, 32'h6000_00AA, 2'd1, 4'b1111, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 2'd0, 4'b1111, 0);
    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
           (($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15))),
           ($urandom_range(0, 63) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
